// File: rtl/rgf_dump_streamer.sv
// rtl/rgf_dump_streamer.sv - snapshot the register file and stream it out word by word
module rgf_dump_streamer #(
    parameter int NUM_REGS    = 32,
    parameter bit CHECKSUM_EN = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REGS*32-1:0]      data_register_file,
    input  logic                        start,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [31:0]                 out_data,
    output logic [$clog2(NUM_REGS)-1:0] out_index,
    output logic                        out_is_csum,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [31:0]      snap [NUM_REGS];
    logic [IDX_W-1:0] counter;
    logic [31:0]      accum;
    logic             done_q;
    logic             xfer;
    logic             capture;

    assign xfer    = out_valid && out_ready;
    assign capture = (state == IDLE) && start;
    assign done    = done_q;

    // Snapshot buffer: loaded only on an accepted start so later bus changes never leak into a dump
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                snap[i] <= data_register_file[i*32 +: 32];
            end
        end
    end

    // State, word counter, running checksum and the completion pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            counter <= '0;
            accum   <= '0;
            done_q  <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        counter <= '0;
                        accum   <= '0;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        accum   <= accum + snap[counter];
                        counter <= counter + IDX_W'(1);
                        if (counter == LAST_IDX && !CHECKSUM_EN) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and beat payload; payload depends only on state/counter so it holds until a transfer
    always_comb begin
        next_state  = state;
        out_valid   = 1'b0;
        out_data    = '0;
        out_index   = '0;
        out_is_csum = 1'b0;
        out_last    = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = snap[counter];
                out_index = counter;
                out_last  = !CHECKSUM_EN && (counter == LAST_IDX);
                if (xfer && counter == LAST_IDX) begin
                    next_state = CHECKSUM_EN ? CSUM : IDLE;
                end
            end
            CSUM: begin
                busy        = 1'b1;
                out_valid   = 1'b1;
                out_data    = accum;
                out_is_csum = 1'b1;
                out_last    = 1'b1;
                if (xfer) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rgf_dump_streamer.sv
// tb/tb_rgf_dump_streamer.sv - scoreboard bench for rgf_dump_streamer
module tb_rgf_dump_streamer;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  index;
        logic        csum;
        logic        last;
    } beat_t;

    logic          clk;
    logic          reset;
    logic [1023:0] data_rf;
    logic          start0, start1;
    logic          ready0, ready1;

    logic        v0, c0, l0, b0, d0;
    logic [31:0] dt0;
    logic [4:0]  ix0;
    logic        v1, c1, l1, b1, d1;
    logic [31:0] dt1;
    logic [4:0]  ix1;

    int sel;
    logic        m_valid, m_csum, m_last, m_busy, m_done, m_ready;
    logic [31:0] m_data;
    logic [4:0]  m_index;

    int errors = 0;
    int checks = 0;
    beat_t sb[$];

    rgf_dump_streamer #(.NUM_REGS(32), .CHECKSUM_EN(1'b1)) u0 (
        .clk(clk), .reset(reset), .data_register_file(data_rf), .start(start0),
        .out_ready(ready0), .out_valid(v0), .out_data(dt0), .out_index(ix0),
        .out_is_csum(c0), .out_last(l0), .busy(b0), .done(d0)
    );

    rgf_dump_streamer #(.NUM_REGS(32), .CHECKSUM_EN(1'b0)) u1 (
        .clk(clk), .reset(reset), .data_register_file(data_rf), .start(start1),
        .out_ready(ready1), .out_valid(v1), .out_data(dt1), .out_index(ix1),
        .out_is_csum(c1), .out_last(l1), .busy(b1), .done(d1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        m_valid = (sel == 1) ? v1  : v0;
        m_data  = (sel == 1) ? dt1 : dt0;
        m_index = (sel == 1) ? ix1 : ix0;
        m_csum  = (sel == 1) ? c1  : c0;
        m_last  = (sel == 1) ? l1  : l0;
        m_busy  = (sel == 1) ? b1  : b0;
        m_done  = (sel == 1) ? d1  : d0;
        m_ready = (sel == 1) ? ready1 : ready0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_data(input logic [31:0] base, input bit incr);
        for (int i = 0; i < 32; i++) begin
            data_rf[i*32 +: 32] = incr ? base + 32'(i) : base;
        end
    endtask

    task automatic push_dump(input logic [31:0] base, input bit incr, input bit with_csum);
        logic [31:0] w;
        logic [31:0] sum;
        beat_t b;
        sum = '0;
        for (int i = 0; i < 32; i++) begin
            w = incr ? base + 32'(i) : base;
            sum = sum + w;
            b.data  = w;
            b.index = 5'(i);
            b.csum  = 1'b0;
            b.last  = !with_csum && (i == 31);
            sb.push_back(b);
        end
        if (with_csum) begin
            b.data  = sum;
            b.index = 5'd0;
            b.csum  = 1'b1;
            b.last  = 1'b1;
            sb.push_back(b);
        end
    endtask

    task automatic do_start();
        @(posedge clk);
        #1;
        if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic set_ready(input logic r);
        ready0 = r;
        ready1 = r;
    endtask

    task automatic collect(input int ready_mode, input int restart_idx, input int reset_idx,
                           input int budget, output int nx, output int nb, output int nd,
                           output bit done_ok, output bit bubble_free);
        int cyc = 0;
        int first_x = -1;
        int last_x = -10;
        int done_at = -1;
        bit hold = 1'b0;
        beat_t held, cur, exp;
        nx = 0; nb = 0; nd = 0; done_ok = 1'b0; bubble_free = 1'b0;
        set_ready(ready_mode == 0);
        while (cyc < budget) begin
            @(negedge clk);
            cur = {m_data, m_index, m_csum, m_last};
            if (m_busy) nb++;
            if (m_done) begin
                nd++;
                if (done_at < 0) done_at = cyc;
            end
            if (hold) chk("hold_stable", {m_valid, cur}, {1'b1, held});
            if (m_valid && reset_idx >= 0 && !m_csum && int'(m_index) == reset_idx) begin
                reset = 1'b0;
                #1;
                chk("async_rst_valid", 64'(m_valid), 64'd0);
                chk("async_rst_busy", 64'(m_busy), 64'd0);
                sb.delete();
                return;
            end
            if (m_valid && restart_idx >= 0 && !m_csum && int'(m_index) == restart_idx) begin
                if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_beat", 64'(cur), 64'd0);
                end else begin
                    exp = sb.pop_front();
                    chk("beat", 64'(cur), 64'(exp));
                end
                nx++;
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
            end
            hold = m_valid && !m_ready;
            held = cur;
            if (done_at >= 0 && cyc >= done_at + 2) break;
            @(posedge clk);
            #1;
            start0 = 1'b0;
            start1 = 1'b0;
            if (ready_mode == 1) set_ready(!m_ready);
            cyc++;
        end
        done_ok = (done_at == last_x + 1);
        bubble_free = (first_x >= 0) && (last_x - first_x + 1 == nx);
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int nx, nb, nd;
        bit dok, bf;
        sel = 0;
        reset = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        set_ready(1'b1);
        data_rf = '0;
        fill_data(32'h1000_0000, 1'b1);
        #1;
        chk("rst_valid", 64'(v0), 64'd0);
        chk("rst_busy", 64'(b0), 64'd0);
        chk("rst_done", 64'(d0), 64'd0);
        chk("rst_last", 64'(l0), 64'd0);
        chk("rst_csum", 64'(c0), 64'd0);
        chk("rst_data", 64'(dt0), 64'd0);
        chk("rst_index", 64'(ix0), 64'd0);
        chk("rst_valid_nocsum", 64'(v1), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Full dump, ready held high
        push_dump(32'h1000_0000, 1'b1, 1'b1);
        chk("csum_model", 64'(sb[32].data), 64'h1F0);
        do_start();
        collect(0, -1, -1, 200, nx, nb, nd, dok, bf);
        chk("a_xfers", 64'(nx), 64'd33);
        chk("a_busy_cycles", 64'(nb), 64'd33);
        chk("a_done_pulses", 64'(nd), 64'd1);
        chk("a_done_timing", 64'(dok), 64'd1);
        chk("a_no_bubbles", 64'(bf), 64'd1);

        // Ready toggling every cycle
        push_dump(32'h1000_0000, 1'b1, 1'b1);
        do_start();
        collect(1, -1, -1, 300, nx, nb, nd, dok, bf);
        chk("b_xfers", 64'(nx), 64'd33);
        chk("b_done_pulses", 64'(nd), 64'd1);

        // Bus changes right after capture do not reach the stream
        push_dump(32'h1000_0000, 1'b1, 1'b1);
        do_start();
        data_rf = '1;
        collect(0, -1, -1, 200, nx, nb, nd, dok, bf);
        chk("c_xfers", 64'(nx), 64'd33);
        fill_data(32'h1000_0000, 1'b1);

        // Second start mid-dump is ignored
        push_dump(32'h1000_0000, 1'b1, 1'b1);
        do_start();
        collect(0, 10, -1, 200, nx, nb, nd, dok, bf);
        chk("d_xfers", 64'(nx), 64'd33);
        chk("d_done_pulses", 64'(nd), 64'd1);

        // Reset mid-stream, then a fresh dump from index 0
        push_dump(32'h1000_0000, 1'b1, 1'b1);
        do_start();
        collect(0, -1, 5, 200, nx, nb, nd, dok, bf);
        chk("e_xfers_before_rst", 64'(nx), 64'd5);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("e_idle_valid", 64'(v0), 64'd0);
        chk("e_idle_busy", 64'(b0), 64'd0);
        push_dump(32'h1000_0000, 1'b1, 1'b1);
        do_start();
        collect(0, -1, -1, 200, nx, nb, nd, dok, bf);
        chk("e_xfers", 64'(nx), 64'd33);
        chk("e_done_timing", 64'(dok), 64'd1);

        // No checksum variant
        sel = 1;
        fill_data(32'hA5A5_A5A5, 1'b0);
        push_dump(32'hA5A5_A5A5, 1'b0, 1'b0);
        do_start();
        collect(0, -1, -1, 200, nx, nb, nd, dok, bf);
        chk("f_xfers", 64'(nx), 64'd32);
        chk("f_busy_cycles", 64'(nb), 64'd32);
        chk("f_done_pulses", 64'(nd), 64'd1);
        chk("f_done_timing", 64'(dok), 64'd1);
        chk("f_valid_after", 64'(v1), 64'd0);
        chk("f_other_idle", 64'(v0), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
